uart_rx: RTL and testbench

//  Serial receiver for the MIDI router's UART link, the receive-side counterpart of the TX shifter.

---
 rtl/midi_uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/midi_uart_pkg.sv
// Shared definitions for the MIDI router UART link (uart_tx / uart_rx).
// Both sides take the baud divisor from here so that they agree on the bit timing.
package midi_uart_pkg;

  // clk cycles per bit period (clk = baud x OVERSAMPLE); must be even and >= 4
  localparam int OVERSAMPLE_DEF = 8;
  // data bits per frame; no parity, one stop bit
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two flops back to back give the first stage a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments keep this a two-stage shift; blocking would collapse it to one flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// MIDI IN serial receiver: start-bit validation, mid-bit sampling of LSB-first data,
// stop-bit check, and a valid/read handshake towards the message parser.
module uart_rx
  import midi_uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rd_strobe,
  output logic [DATA_BITS-1:0] data,
  output logic                 rx_valid,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  uart_state_t          state_q, state_d;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] sr;

  logic cnt_clr;     // restart the bit-period counter
  logic start_ok;    // start bit confirmed low at mid-bit
  logic bit_tick;    // mid-bit of a data bit: shift rx_s in
  logic stop_ok;     // stop bit sampled high: publish the byte
  logic stop_bad;    // stop bit sampled low: framing error

  // The line idles high, so the synchroniser resets to 1 to avoid a false start bit.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_clr  = 1'b0;
    start_ok = 1'b0;
    bit_tick = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_clr = 1'b1;
        end
      end
      S_START: begin
        if (cnt == CNT_HALF) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            state_d = S_IDLE;     // glitch shorter than half a bit
          end else begin
            state_d  = S_DATA;
            start_ok = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_clr  = 1'b1;
          bit_tick = 1'b1;
          if (bit_cnt == BIT_LAST) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            stop_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bit-period counter, data bit index and receive shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
      sr      <= '0;
    end else begin
      if (cnt_clr || state_q == S_IDLE || state_q == S_BREAK) cnt <= '0;
      else                                                     cnt <= cnt + 1'b1;

      if (start_ok)      bit_cnt <= '0;
      else if (bit_tick) bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;

      if (bit_tick) sr <= {rx_s, sr[DATA_BITS-1:1]};
    end
  end

  // Output registers: a good stop bit takes priority over a read in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (stop_ok) begin
        data     <= sr;
        rx_valid <= 1'b1;
        overrun  <= rx_valid & ~rd_strobe;
      end else if (rd_strobe && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at OVERSAMPLE=8, DATA_BITS=8.
// rx and rd_strobe are driven on the falling clock edge; outputs are read there too.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd_strobe = 1'b0;
  logic [7:0] data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;

  uart_rx #(.OVERSAMPLE(8), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_strobe (rd_strobe),
    .data      (data),
    .rx_valid  (rx_valid),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Count frame_err pulses, one per cycle they are high.
  always @(negedge clk) if (frame_err) fe_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one 10-bit frame, 8 clk per bit. Iteration i drives rx before rising edge i.
  // rise_at is the iteration at which a 0->1 rx_valid transition was first seen (-1 if none),
  // mid_busy is busy sampled half way through the frame. rd_strobe is high for the edge rd_at.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rd_at,
                            output int rise_at, output logic mid_busy);
    logic [9:0] frame;
    logic       prev;
    frame    = {stop_bit, b, 1'b0};
    rise_at  = -1;
    mid_busy = 1'b0;
    prev     = rx_valid;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rise_at < 0 && rx_valid && !prev) rise_at = i;
      prev = rx_valid;
      if (i == 40) mid_busy = busy;
      rx        = frame[i/8];
      rd_strobe = (i == rd_at);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx        = 1'b1;
      rd_strobe = 1'b0;
    end
  endtask

  task automatic read_pulse();
    @(negedge clk);
    rd_strobe = 1'b1;
    @(negedge clk);
    rd_strobe = 1'b0;
  endtask

  initial begin
    int   rise;
    logic mb;
    int   fe0;
    logic [9:0] part;

    // Reset state
    #1;
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_cycles(4);

    // 1. Frame 0x90: rx_valid rises after the stop sample (edge 78, seen at iteration 79)
    send_frame(8'h90, 1'b1, -1, rise, mb);
    check("t1_rise_cycle", 32'(rise), 79);
    check("t1_mid_busy", 32'(mb), 1);
    check("t1_data", 32'(data), 32'h90);
    check("t1_valid", 32'(rx_valid), 1);
    check("t1_frame_err", 32'(fe_cnt), 0);
    check("t1_busy", 32'(busy), 0);
    read_pulse();
    check("t1_read_clr", 32'(rx_valid), 0);
    idle_cycles(4);

    // 2. Three-cycle low glitch: START samples 1 and returns to IDLE
    fe0 = fe_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    @(negedge clk);
    check("t2_busy_start", 32'(busy), 1);
    rx = 1'b1;
    idle_cycles(12);
    check("t2_busy", 32'(busy), 0);
    check("t2_valid", 32'(rx_valid), 0);
    check("t2_frame_err", 32'(fe_cnt - fe0), 0);

    // 3. 0x3C with low stop bit, line held low (break), then 0x45
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1, rise, mb);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    check("t3_busy_break", 32'(busy), 1);
    check("t3_valid_break", 32'(rx_valid), 0);
    idle_cycles(5);
    check("t3_busy_after", 32'(busy), 0);
    check("t3_frame_err_cnt", 32'(fe_cnt - fe0), 1);
    check("t3_valid", 32'(rx_valid), 0);
    check("t3_data_kept", 32'(data), 32'h90);
    send_frame(8'h45, 1'b1, -1, rise, mb);
    check("t3_next_data", 32'(data), 32'h45);
    check("t3_next_valid", 32'(rx_valid), 1);
    read_pulse();
    idle_cycles(2);

    // 4. 0xF8 then 0x7F back to back, nothing read: overrun
    send_frame(8'hF8, 1'b1, -1, rise, mb);
    check("t4_first_overrun", 32'(overrun), 0);
    send_frame(8'h7F, 1'b1, -1, rise, mb);
    check("t4_data", 32'(data), 32'h7F);
    check("t4_valid", 32'(rx_valid), 1);
    check("t4_overrun", 32'(overrun), 1);
    read_pulse();
    check("t4_valid_clr", 32'(rx_valid), 0);
    check("t4_overrun_clr", 32'(overrun), 0);
    read_pulse();
    check("t4_idle_read", 32'(overrun), 0);
    idle_cycles(2);

    // 5. Read coincides with the 0x7F stop sample: new byte wins, no overrun
    send_frame(8'hF8, 1'b1, -1, rise, mb);
    send_frame(8'h7F, 1'b1, 78, rise, mb);
    check("t5_data", 32'(data), 32'h7F);
    check("t5_valid", 32'(rx_valid), 1);
    check("t5_overrun", 32'(overrun), 0);

    // 6. Reset during data bit 4 of 0xAA (frame slot 5), then 0x55
    part = {1'b1, 8'hAA, 1'b0};
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      rx = part[i/8];
    end
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    check("t6_rst_data", 32'(data), 32'h00);
    check("t6_rst_valid", 32'(rx_valid), 0);
    check("t6_rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_cycles(4);
    send_frame(8'h55, 1'b1, -1, rise, mb);
    check("t6_rise_cycle", 32'(rise), 79);
    check("t6_data", 32'(data), 32'h55);
    check("t6_overrun", 32'(overrun), 0);

    idle_cycles(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
